anode_scan_decoder: RTL and testbench

- Sequential 3-to-8 decoder for multiplexed 8-digit seven-segment displays; the inverse of the 8x3 one-hot encoder.
- A prescaler sets the refresh rate and advances a 3-bit digit index.
- The index is decoded to one-hot digit enables, then masked and polarity-adjusted onto the board anode pins.
- Sits between the display data mux, which uses the exported index to pick segment data, and the anode pins.

---
 rtl/scan_pkg.sv | 17 +
 rtl/decoder3x8.sv | 14 +
 rtl/anode_scan_decoder.sv | 97 +++++++++
 tb/tb_anode_scan_decoder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types and constants for the multiplexed seven-segment anode scanner.
package scan_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int IDX_W      = 3;

    typedef logic [IDX_W-1:0]      digit_idx_t;
    typedef logic [NUM_DIGITS-1:0] digit_vec_t;

    localparam digit_vec_t ONEHOT_RST = 8'h01;

    // Anode pattern with no digit lit, for the given pin polarity.
    function automatic digit_vec_t an_inactive(input bit active_low);
        return active_low ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    endfunction

endpackage

// File: rtl/decoder3x8.sv
// Combinational 3-bit index to 8-bit one-hot decoder; all index values are legal.
module decoder3x8
    import scan_pkg::*;
(
    input  digit_idx_t idx_i,
    output digit_vec_t onehot_o
);

    always_comb begin
        onehot_o        = '0;
        onehot_o[idx_i] = 1'b1;
    end

endmodule

// File: rtl/anode_scan_decoder.sv
// Digit scanner for an 8-digit multiplexed display: prescaler, digit index,
// one-hot decode and masked, polarity-adjusted anode drive, all registered.
module anode_scan_decoder
    import scan_pkg::*;
#(
    parameter int unsigned DIV_MAX    = 100000,
    parameter int unsigned DIV_WIDTH  = 17,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 hold,
    input  logic                 load,
    input  logic [IDX_W-1:0]     load_idx,
    input  logic [NUM_DIGITS-1:0] digit_mask,
    output logic [IDX_W-1:0]     sel,
    output logic [NUM_DIGITS-1:0] onehot,
    output logic [NUM_DIGITS-1:0] an,
    output logic                 tick
);

    localparam logic [DIV_WIDTH-1:0] CNT_LAST = DIV_WIDTH'(DIV_MAX - 1);

    logic [DIV_WIDTH-1:0] count_q, count_d;
    digit_idx_t           sel_q, sel_d, run_idx;
    digit_vec_t           onehot_q, onehot_d, run_onehot, load_onehot;
    digit_vec_t           an_q, an_d;
    logic                 tick_q, tick_d;
    logic                 wrap;

    function automatic digit_vec_t drive_an(input logic       scan_en,
                                            input digit_vec_t dec,
                                            input digit_vec_t mask);
        digit_vec_t act;
        act = scan_en ? (dec & mask) : '0;
        return ACTIVE_LOW ? ~act : act;
    endfunction

    assign wrap = (count_q == CNT_LAST);

    // Prescaler and index advance; load overrides everything, including a same-cycle wrap.
    always_comb begin
        count_d = count_q;
        run_idx = sel_q;
        tick_d  = 1'b0;
        if (load) begin
            count_d = '0;
        end else if (en) begin
            if (wrap) begin
                count_d = '0;
                tick_d  = 1'b1;
                if (!hold) begin
                    run_idx = sel_q + 3'd1;
                end
            end else begin
                count_d = count_q + DIV_WIDTH'(1);
            end
        end
        sel_d = load ? load_idx : run_idx;
    end

    decoder3x8 u_dec_run (
        .idx_i    (run_idx),
        .onehot_o (run_onehot)
    );

    decoder3x8 u_dec_load (
        .idx_i    (load_idx),
        .onehot_o (load_onehot)
    );

    assign onehot_d = load ? load_onehot : run_onehot;
    assign an_d     = drive_an(en, onehot_d, digit_mask);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            sel_q    <= '0;
            onehot_q <= ONEHOT_RST;
            an_q     <= an_inactive(ACTIVE_LOW);
            tick_q   <= 1'b0;
        end else begin
            count_q  <= count_d;
            sel_q    <= sel_d;
            onehot_q <= onehot_d;
            an_q     <= an_d;
            tick_q   <= tick_d;
        end
    end

    assign sel    = sel_q;
    assign onehot = onehot_q;
    assign an     = an_q;
    assign tick   = tick_q;

endmodule

// File: tb/tb_anode_scan_decoder.sv
// Scoreboard bench: a cycle model queues expected outputs as stimulus is applied.
module tb_anode_scan_decoder;

    localparam int DIV = 4;

    logic       clk = 1'b0, clk_run = 1'b0;
    logic       rst = 1'b0, rst2 = 1'b0;
    logic       en = 1'b0, hold = 1'b0, load = 1'b0;
    logic [2:0] load_idx = 3'd0;
    logic [7:0] mask = 8'hFF;

    logic [2:0] sel, sel2;
    logic [7:0] onehot, onehot2, an, an2;
    logic       tick, tick2;

    anode_scan_decoder #(.DIV_MAX(DIV), .DIV_WIDTH(3), .ACTIVE_LOW(1'b1)) u_dut (
        .clk(clk), .rst(rst), .en(en), .hold(hold), .load(load),
        .load_idx(load_idx), .digit_mask(mask),
        .sel(sel), .onehot(onehot), .an(an), .tick(tick)
    );

    anode_scan_decoder #(.DIV_MAX(DIV), .DIV_WIDTH(3), .ACTIVE_LOW(1'b0)) u_dut_ah (
        .clk(clk), .rst(rst2), .en(en), .hold(hold), .load(load),
        .load_idx(load_idx), .digit_mask(mask),
        .sel(sel2), .onehot(onehot2), .an(an2), .tick(tick2)
    );

    initial forever begin
        #5;
        if (clk_run) clk = ~clk;
    end

    typedef struct packed {
        logic [2:0] sel;
        logic [7:0] oh;
        logic [7:0] an;
        logic       tick;
    } exp_t;

    exp_t       sb_q[$];
    int         n_vec = 0, n_err = 0;
    int         m_cnt;
    logic [2:0] m_sel;
    logic       m_tick;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_sel  = 3'd0;
        m_tick = 1'b0;
        sb_q.delete();
    endtask

    // Advance the model by one edge using the inputs now applied; queue the result.
    task automatic model_step();
        exp_t       e;
        logic [7:0] oh, act;
        if (load) begin
            m_cnt  = 0;
            m_sel  = load_idx;
            m_tick = 1'b0;
        end else if (en) begin
            if (m_cnt == DIV - 1) begin
                m_cnt  = 0;
                m_tick = 1'b1;
                if (!hold) m_sel = m_sel + 3'd1;
            end else begin
                m_cnt  = m_cnt + 1;
                m_tick = 1'b0;
            end
        end else begin
            m_tick = 1'b0;
        end
        oh     = 8'h01 << m_sel;
        act    = en ? (oh & mask) : 8'h00;
        e.sel  = m_sel;
        e.oh   = oh;
        e.an   = ~act;
        e.tick = m_tick;
        sb_q.push_back(e);
    endtask

    task automatic cycle();
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_vec("sel", sel, e.sel);
        check_vec("onehot", onehot, e.oh);
        check_vec("an", an, e.an);
        check_vec("tick", tick, e.tick);
    endtask

    initial begin
        int   n;
        int   ticks;
        logic [2:0] sel_h;

        // Reset with no clock running
        #1 rst = 1'b1; rst2 = 1'b1;
        #1;
        check_vec("rst_sel", sel, 3'd0);
        check_vec("rst_onehot", onehot, 8'h01);
        check_vec("rst_an", an, 8'hFF);
        check_vec("rst_tick", tick, 1'b0);
        check_vec("rst_an_ah", an2, 8'h00);
        clk_run = 1'b1;
        @(posedge clk);
        #1;
        en   = 1'b1;
        rst  = 1'b0;
        model_reset();

        // Normal scan
        for (int k = 0; k < 4; k++) cycle();
        check_vec("scan_sel", sel, 3'd1);
        check_vec("scan_onehot", onehot, 8'h02);
        check_vec("scan_an", an, 8'hFD);
        check_vec("scan_tick", tick, 1'b1);
        for (int k = 0; k < 12; k++) begin
            cycle();
            check_vec("tick_period", tick, (k % 4 == 3));
        end

        // Wrap-around 7 -> 0
        n = 0;
        while (m_sel != 3'd7 && n < 64) begin cycle(); n++; end
        check_vec("reach7_timeout", (n < 64), 1'b1);
        check_vec("sel7_an", an, 8'h7F);
        n = 0;
        do begin cycle(); n++; end while (!m_tick && n < 64);
        check_vec("wrap_sel", sel, 3'd0);
        check_vec("wrap_onehot", onehot, 8'h01);
        check_vec("wrap_an", an, 8'hFE);

        // Load collides with wrap
        n = 0;
        while (m_cnt != DIV - 1 && n < 16) begin cycle(); n++; end
        load = 1'b1; load_idx = 3'd5;
        cycle();
        load = 1'b0;
        check_vec("load_sel", sel, 3'd5);
        check_vec("load_an", an, 8'hDF);
        check_vec("load_tick", tick, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            cycle();
            check_vec("post_load_tick", tick, (k == 4));
        end
        check_vec("post_load_sel", sel, 3'd6);

        // Mask blanks the active digit
        n = 0;
        do begin cycle(); n++; end while (!(m_sel == 3'd0 && m_tick) && n < 64);
        mask = 8'hFE;
        cycle();
        check_vec("mask_an", an, 8'hFF);
        check_vec("mask_onehot", onehot, 8'h01);
        mask = 8'hFF;

        // Hold: index frozen, prescaler still ticks
        hold  = 1'b1;
        sel_h = m_sel;
        ticks = 0;
        for (int k = 0; k < 12; k++) begin cycle(); ticks += tick; end
        check_vec("hold_ticks", ticks, 3);
        check_vec("hold_sel", sel, sel_h);
        hold = 1'b0;

        // Scan disabled
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check_vec("dis_an", an, 8'hFF);
            check_vec("dis_tick", tick, 1'b0);
            check_vec("dis_sel", sel, sel_h);
        end
        en = 1'b1;
        for (int k = 0; k < 8; k++) cycle();

        // Every load index decodes
        for (int i = 0; i < 8; i++) begin
            load = 1'b1; load_idx = 3'(i);
            cycle();
            check_vec("load_decode", onehot, 8'h01 << i);
        end
        load = 1'b0;

        // Async reset mid-scan on the active-high build
        rst2 = 1'b0;
        for (int k = 0; k < 6 * DIV; k++) cycle();
        check_vec("ah_sel6", sel2, 3'd6);
        check_vec("ah_an6", an2, 8'h40);
        #2 rst2 = 1'b1;
        #1;
        check_vec("ah_rst_sel", sel2, 3'd0);
        check_vec("ah_rst_an", an2, 8'h00);
        check_vec("ah_rst_onehot", onehot2, 8'h01);
        check_vec("ah_rst_tick", tick2, 1'b0);
        rst2 = 1'b0;
        for (int k = 1; k <= DIV; k++) begin
            cycle();
            check_vec("ah_count0_tick", tick2, (k == DIV));
        end
        check_vec("ah_resume_sel", sel2, 3'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
